fab_cell: RTL and testbench



---
 rtl/fab_full_adder.sv | 14 +
 rtl/fab_cell.sv | 57 +++++
 tb/tb_fab_cell.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fab_full_adder.sv
// Single-bit full adder used as the arithmetic core of each fab_cell lane.
// Purely combinational: s = a ^ b ^ c, co = majority(a, b, c).
module fab_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fab_cell.sv
// W independent AND-plus-full-adder lanes for carry-save array multipliers,
// with an optional single-stage output register selected by REG_OUT.
module fab_cell #(
  parameter int W       = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] sin,
  input  logic [W-1:0] cin,
  output logic [W-1:0] sout,
  output logic [W-1:0] cout
);

  logic [W-1:0] pp_s;
  logic [W-1:0] sum_s;
  logic [W-1:0] carry_s;

  assign pp_s = x & y;

  for (genvar i = 0; i < W; i++) begin : g_lane
    fab_full_adder u_fa (
      .a  (pp_s[i]),
      .b  (sin[i]),
      .c  (cin[i]),
      .s  (sum_s[i]),
      .co (carry_s[i])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [W-1:0] sout_r;
    logic [W-1:0] cout_r;

    // Pipeline register; reset clears outputs immediately and drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sout_r <= {W{1'b0}};
        cout_r <= {W{1'b0}};
      end else begin
        sout_r <= sum_s;
        cout_r <= carry_s;
      end
    end

    assign sout = sout_r;
    assign cout = cout_r;
  end else begin : g_comb
    logic unused_s;
    assign unused_s = clk ^ rst_n;
    assign sout     = sum_s;
    assign cout     = carry_s;
  end

endmodule

// File: tb/tb_fab_cell.sv
// Self-checking bench for fab_cell: directed table, exhaustive W=1 sweep,
// W=4 lane independence, and registered-variant reset/latency/random streaming.
module tb_fab_cell;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] sin;
    logic [3:0] cin;
    logic [3:0] sout;
    logic [3:0] cout;
  } vec_t;

  typedef struct {
    logic sout;
    logic cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic cx, cy, cs, cc, c_sout, c_cout;
  logic [3:0] wx, wy, ws, wc, w_sout, w_cout;
  logic rx, ry, rs, rc, r_sout, r_cout;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  fab_cell #(.W(1), .REG_OUT(1'b0)) u_comb1 (
    .clk(clk), .rst_n(rst_n), .x(cx), .y(cy), .sin(cs), .cin(cc),
    .sout(c_sout), .cout(c_cout)
  );

  fab_cell #(.W(4), .REG_OUT(1'b0)) u_comb4 (
    .clk(clk), .rst_n(rst_n), .x(wx), .y(wy), .sin(ws), .cin(wc),
    .sout(w_sout), .cout(w_cout)
  );

  fab_cell #(.W(1), .REG_OUT(1'b1)) u_reg1 (
    .clk(clk), .rst_n(rst_n), .x(rx), .y(ry), .sin(rs), .cin(rc),
    .sout(r_sout), .cout(r_cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
    $fatal(1);
  end

  // Arithmetic reference: {cout,sout} = (x&y) + sin + cin
  function automatic exp_t model(input logic x, input logic y, input logic s, input logic c);
    logic [1:0] t;
    exp_t e;
    t = {1'b0, x & y} + {1'b0, s} + {1'b0, c};
    e.sout = t[0];
    e.cout = t[1];
    return e;
  endfunction

  task automatic check(input string name, input logic [3:0] act_s, input logic [3:0] act_c,
                       input logic [3:0] exp_s, input logic [3:0] exp_c);
    tests++;
    if (act_s !== exp_s || act_c !== exp_c) begin
      fails++;
      $display("FAIL %s: got sout=%b cout=%b, expected sout=%b cout=%b",
               name, act_s, act_c, exp_s, exp_c);
    end
  endtask

  initial begin
    vec_t vt[7];
    exp_t e;
    exp_t q;

    // W=1 directed vectors plus the W=4 lane-independence vector (last entry)
    vt[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vt[1] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    vt[2] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    vt[3] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
    vt[4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
    vt[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    vt[6] = '{4'b1010, 4'b1111, 4'b0110, 4'b0011, 4'b1111, 4'b0010};

    cx = 1'b0; cy = 1'b0; cs = 1'b0; cc = 1'b0;
    wx = 4'b0000; wy = 4'b0000; ws = 4'b0000; wc = 4'b0000;
    rx = 1'b1; ry = 1'b1; rs = 1'b1; rc = 1'b1;

    // Combinational directed table (rst_n low: must not matter)
    for (int i = 0; i < 6; i++) begin
      cx = vt[i].x[0]; cy = vt[i].y[0]; cs = vt[i].sin[0]; cc = vt[i].cin[0];
      #1;
      check($sformatf("comb_dir%0d", i), {3'b000, c_sout}, {3'b000, c_cout},
            vt[i].sout, vt[i].cout);
    end

    wx = vt[6].x; wy = vt[6].y; ws = vt[6].sin; wc = vt[6].cin;
    #1;
    check("comb_w4_lanes", w_sout, w_cout, vt[6].sout, vt[6].cout);

    // Reset holds registered outputs at 0 across a clock edge with all-ones inputs
    @(posedge clk); #1;
    check("reg_in_reset", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0000, 4'b0000);

    // Exhaustive W=1 sweep, rst_n high this time
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] bits;
      bits = v[3:0];
      cx = bits[3]; cy = bits[2]; cs = bits[1]; cc = bits[0];
      #1;
      e = model(bits[3], bits[2], bits[1], bits[0]);
      check($sformatf("comb_exh%0d", v), {3'b000, c_sout}, {3'b000, c_cout},
            {3'b000, e.sout}, {3'b000, e.cout});
    end

    // Registered: 1,1,1,1 loaded on first edge after reset release
    @(posedge clk); #1;
    check("reg_first_load", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0001, 4'b0001);

    // Async reset between edges clears outputs immediately
    #2 rst_n = 1'b0;
    #1;
    check("reg_async_clear", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    check("reg_held_reset", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0000, 4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    rx = 1'b1; ry = 1'b1; rs = 1'b0; rc = 1'b1;
    #1;
    check("reg_no_load_before_edge", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    check("reg_after_release", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0000, 4'b0001);

    // Random back-to-back stream through the scoreboard
    for (int n = 0; n < 1000; n++) begin
      logic [3:0] r;
      @(negedge clk);
      r = 4'($urandom_range(0, 15));
      rx = r[3]; ry = r[2]; rs = r[1]; rc = r[0];
      sb.push_back(model(r[3], r[2], r[1], r[0]));
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL reg_stream%0d: scoreboard empty, expected one entry", n);
      end else begin
        q = sb.pop_front();
        check($sformatf("reg_stream%0d", n), {3'b000, r_sout}, {3'b000, r_cout},
              {3'b000, q.sout}, {3'b000, q.cout});
      end
    end

    // Mid-stream reset discards the in-flight result
    @(negedge clk);
    rx = 1'b1; ry = 1'b1; rs = 1'b1; rc = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reg_midstream_clear", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0000, 4'b0000);
    @(posedge clk); #1;
    check("reg_midstream_discard", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    rx = 1'b0; ry = 1'b1; rs = 1'b1; rc = 1'b0;
    @(posedge clk); #1;
    check("reg_resume_halfadd", {3'b000, r_sout}, {3'b000, r_cout}, 4'b0001, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
